// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic ops, multi-cycle bit-serial shifts,
// valid/ready handshake on both sides with registered result and flags.
module alu_seq #(
    parameter int NB_DATA  = 8,
    parameter int NB_OP    = 6,
    parameter int NB_SHAMT = 3
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [NB_DATA-1:0]  i_a,
    input  logic [NB_DATA-1:0]  i_b,
    input  logic [NB_OP-1:0]    i_op,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [NB_DATA-1:0]  o_result,
    output logic                o_zero,
    output logic                o_negative,
    output logic                o_carry,
    output logic                o_overflow,
    output logic                o_illegal
);

    localparam logic [5:0] OP_ADD  = 6'b100000;
    localparam logic [5:0] OP_SUB  = 6'b100010;
    localparam logic [5:0] OP_AND  = 6'b100100;
    localparam logic [5:0] OP_OR   = 6'b100101;
    localparam logic [5:0] OP_XOR  = 6'b100110;
    localparam logic [5:0] OP_NOR  = 6'b100111;
    localparam logic [5:0] OP_SLT  = 6'b101010;
    localparam logic [5:0] OP_SLTU = 6'b101011;
    localparam logic [5:0] OP_SLL  = 6'b000000;
    localparam logic [5:0] OP_SRL  = 6'b000010;
    localparam logic [5:0] OP_SRA  = 6'b000011;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
    typedef enum logic [1:0] {K_SLL, K_SRL, K_SRA} kind_t;

    state_t                r_state;
    kind_t                 r_kind;
    logic [NB_DATA-1:0]    r_work;
    logic [NB_SHAMT-1:0]   r_cnt;
    logic [NB_DATA-1:0]    r_result;
    logic                  r_zero, r_negative, r_carry, r_overflow, r_illegal;

    logic [5:0]            w_op_lo;
    logic                  w_op_hi_zero;
    logic [NB_SHAMT-1:0]   w_shamt;
    logic [NB_DATA:0]      w_sum, w_diff;
    logic signed [NB_DATA-1:0] w_sa, w_sb;
    logic [NB_DATA-1:0]    w_res;
    logic                  w_c, w_v, w_ill, w_is_shift;
    kind_t                 w_kind;
    logic [NB_DATA-1:0]    w_shift_next;
    logic                  w_shift_out;

    assign w_op_lo      = i_op[5:0];
    assign w_op_hi_zero = ((i_op >> 6) == '0);
    assign w_shamt      = i_b[NB_SHAMT-1:0];
    assign w_sum        = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff       = {1'b0, i_a} - {1'b0, i_b};
    assign w_sa         = i_a;
    assign w_sb         = i_b;

    // Decode and evaluate the single-cycle result for the operands on the inputs.
    always_comb begin
        w_res      = '0;
        w_c        = 1'b0;
        w_v        = 1'b0;
        w_ill      = 1'b0;
        w_is_shift = 1'b0;
        w_kind     = K_SLL;
        if (!w_op_hi_zero) begin
            w_ill = 1'b1;
        end else begin
            case (w_op_lo)
                OP_ADD: begin
                    w_res = w_sum[NB_DATA-1:0];
                    w_c   = w_sum[NB_DATA];
                    w_v   = (i_a[NB_DATA-1] == i_b[NB_DATA-1]) &&
                            (w_sum[NB_DATA-1] != i_a[NB_DATA-1]);
                end
                OP_SUB: begin
                    w_res = w_diff[NB_DATA-1:0];
                    w_c   = w_diff[NB_DATA];
                    w_v   = (i_a[NB_DATA-1] != i_b[NB_DATA-1]) &&
                            (w_diff[NB_DATA-1] != i_a[NB_DATA-1]);
                end
                OP_AND:  w_res = i_a & i_b;
                OP_OR:   w_res = i_a | i_b;
                OP_XOR:  w_res = i_a ^ i_b;
                OP_NOR:  w_res = ~(i_a | i_b);
                OP_SLT:  w_res = {{(NB_DATA-1){1'b0}}, (w_sa < w_sb)};
                OP_SLTU: w_res = {{(NB_DATA-1){1'b0}}, (i_a < i_b)};
                OP_SLL: begin w_is_shift = 1'b1; w_kind = K_SLL; w_res = i_a; end
                OP_SRL: begin w_is_shift = 1'b1; w_kind = K_SRL; w_res = i_a; end
                OP_SRA: begin w_is_shift = 1'b1; w_kind = K_SRA; w_res = i_a; end
                default: w_ill = 1'b1;
            endcase
        end
    end

    always_comb begin
        w_shift_next = {r_work[NB_DATA-2:0], 1'b0};
        w_shift_out  = r_work[NB_DATA-1];
        case (r_kind)
            K_SRL: begin
                w_shift_next = {1'b0, r_work[NB_DATA-1:1]};
                w_shift_out  = r_work[0];
            end
            K_SRA: begin
                w_shift_next = {r_work[NB_DATA-1], r_work[NB_DATA-1:1]};
                w_shift_out  = r_work[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_kind     <= K_SLL;
            r_cnt      <= '0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        if (w_is_shift && (w_shamt != '0)) begin
                            r_work  <= i_a;
                            r_cnt   <= w_shamt;
                            r_kind  <= w_kind;
                            r_state <= S_SHIFT;
                        end else begin
                            r_result   <= w_res;
                            r_zero     <= (w_res == '0);
                            r_negative <= w_res[NB_DATA-1];
                            r_carry    <= w_c;
                            r_overflow <= w_v;
                            r_illegal  <= w_ill;
                            r_state    <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    r_work <= w_shift_next;
                    r_cnt  <= r_cnt - NB_SHAMT'(1);
                    // Outputs only change on the final step so a reset mid-shift exposes nothing.
                    if (r_cnt == NB_SHAMT'(1)) begin
                        r_result   <= w_shift_next;
                        r_zero     <= (w_shift_next == '0);
                        r_negative <= w_shift_next[NB_DATA-1];
                        r_carry    <= w_shift_out;
                        r_overflow <= 1'b0;
                        r_illegal  <= 1'b0;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ready    = (r_state == S_IDLE) && !i_reset;
    assign o_valid    = (r_state == S_DONE);
    assign o_result   = r_result;
    assign o_zero     = r_zero;
    assign o_negative = r_negative;
    assign o_carry    = r_carry;
    assign o_overflow = r_overflow;
    assign o_illegal  = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (NB_DATA = 8): table of hand-computed results
// plus hand-written reset, backpressure and mid-shift reset sequences.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       i_reset, i_valid, i_ready;
    logic [7:0] i_a, i_b;
    logic [5:0] i_op;
    logic       o_ready, o_valid;
    logic [7:0] o_result;
    logic       o_zero, o_negative, o_carry, o_overflow, o_illegal;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_seq #(.NB_DATA(8), .NB_OP(6), .NB_SHAMT(3)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b), .i_op(i_op), .o_valid(o_valid), .i_ready(i_ready),
        .o_result(o_result), .o_zero(o_zero), .o_negative(o_negative),
        .o_carry(o_carry), .o_overflow(o_overflow), .o_illegal(o_illegal)
    );

    // flags packed as {zero, negative, carry, overflow, illegal}
    typedef struct {
        string      name;
        logic [5:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [4:0] flags;
        int         lat;
    } vec_t;

    vec_t vecs[24];

    function automatic logic [4:0] cur_flags();
        return {o_zero, o_negative, o_carry, o_overflow, o_illegal};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        int w;
        w = 0;
        @(negedge clk);
        while (!o_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({v.name, " ready"}, {31'b0, o_ready}, 32'd1);
        i_op = v.op; i_a = v.a; i_b = v.b; i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({v.name, " latency"}, lat, v.lat);
        chk({v.name, " result"}, {24'b0, o_result}, {24'b0, v.res});
        chk({v.name, " flags"}, {27'b0, cur_flags()}, {27'b0, v.flags});
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{"add_ovf",   6'b100000, 8'h7F, 8'h01, 8'h80, 5'b01010, 1};
        vecs[1]  = '{"sub_eq",    6'b100010, 8'h05, 8'h05, 8'h00, 5'b10000, 1};
        vecs[2]  = '{"sub_brw",   6'b100010, 8'h03, 8'h05, 8'hFE, 5'b01100, 1};
        vecs[3]  = '{"add_cry",   6'b100000, 8'hFF, 8'h01, 8'h00, 5'b10100, 1};
        vecs[4]  = '{"sub_ovf",   6'b100010, 8'h80, 8'h01, 8'h7F, 5'b00010, 1};
        vecs[5]  = '{"and",       6'b100100, 8'hF0, 8'h3C, 8'h30, 5'b00000, 1};
        vecs[6]  = '{"or",        6'b100101, 8'hF0, 8'h0F, 8'hFF, 5'b01000, 1};
        vecs[7]  = '{"xor",       6'b100110, 8'hAA, 8'hAA, 8'h00, 5'b10000, 1};
        vecs[8]  = '{"nor",       6'b100111, 8'h00, 8'h00, 8'hFF, 5'b01000, 1};
        vecs[9]  = '{"slt",       6'b101010, 8'hFF, 8'h01, 8'h01, 5'b00000, 1};
        vecs[10] = '{"sltu",      6'b101011, 8'hFF, 8'h01, 8'h00, 5'b10000, 1};
        vecs[11] = '{"sra3",      6'b000011, 8'h90, 8'h03, 8'hF2, 5'b01000, 4};
        vecs[12] = '{"srl3",      6'b000010, 8'h90, 8'h03, 8'h12, 5'b00000, 4};
        vecs[13] = '{"sll1",      6'b000000, 8'h81, 8'h01, 8'h02, 5'b00100, 2};
        vecs[14] = '{"sll0",      6'b000000, 8'h55, 8'h00, 8'h55, 5'b00000, 1};
        vecs[15] = '{"srl1_z",    6'b000010, 8'h01, 8'h01, 8'h00, 5'b10100, 2};
        vecs[16] = '{"srl7",      6'b000010, 8'h80, 8'h07, 8'h01, 5'b00000, 8};
        vecs[17] = '{"sra7",      6'b000011, 8'h80, 8'h07, 8'hFF, 5'b01000, 8};
        vecs[18] = '{"sll7",      6'b000000, 8'h01, 8'h07, 8'h80, 5'b01000, 8};
        vecs[19] = '{"sra_bhi",   6'b000011, 8'h90, 8'h0B, 8'hF2, 5'b01000, 4};
        vecs[20] = '{"illegal3f", 6'b111111, 8'h12, 8'h34, 8'h00, 5'b10001, 1};
        vecs[21] = '{"slt_after", 6'b101010, 8'hFF, 8'h01, 8'h01, 5'b00000, 1};
        vecs[22] = '{"illegal01", 6'b000001, 8'hFF, 8'hFF, 8'h00, 5'b10001, 1};
        vecs[23] = '{"slt_false", 6'b101010, 8'h01, 8'hFF, 8'h00, 5'b10000, 1};
    end

    initial begin
        i_reset = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        i_a = '0; i_b = '0; i_op = '0;
        repeat (3) @(negedge clk);
        chk("rst ready", {31'b0, o_ready}, 32'd0);
        chk("rst valid", {31'b0, o_valid}, 32'd0);
        chk("rst result", {24'b0, o_result}, 32'd0);
        chk("rst flags", {27'b0, cur_flags()}, 32'd0);
        i_reset = 1'b0;
        #1;
        chk("post-rst ready", {31'b0, o_ready}, 32'd1);

        for (int k = 0; k < 24; k++) run_vec(vecs[k]);

        // Backpressure: result holds and no second accept while downstream stalls.
        @(negedge clk);
        i_op = 6'b100000; i_a = 8'h7F; i_b = 8'h01; i_valid = 1'b1;
        @(negedge clk);
        i_a = 8'h01; i_b = 8'h01;
        for (int k = 0; k < 3; k++) begin
            chk("bp valid", {31'b0, o_valid}, 32'd1);
            chk("bp ready", {31'b0, o_ready}, 32'd0);
            chk("bp result", {24'b0, o_result}, 32'h80);
            chk("bp flags", {27'b0, cur_flags()}, {27'b0, 5'b01010});
            @(negedge clk);
        end
        chk("bp held valid", {31'b0, o_valid}, 32'd1);
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        chk("bp idle valid", {31'b0, o_valid}, 32'd0);
        chk("bp idle ready", {31'b0, o_ready}, 32'd1);
        @(negedge clk);
        i_valid = 1'b0;
        chk("bp 2nd valid", {31'b0, o_valid}, 32'd1);
        chk("bp 2nd result", {24'b0, o_result}, 32'h02);
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;

        // Reset in the middle of a 7-step shift discards the operation.
        @(negedge clk);
        i_op = 6'b000010; i_a = 8'hFF; i_b = 8'h07; i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        i_reset = 1'b1;
        #1;
        chk("shrst ready low", {31'b0, o_ready}, 32'd0);
        @(negedge clk);
        i_reset = 1'b0;
        #1;
        chk("shrst valid", {31'b0, o_valid}, 32'd0);
        chk("shrst result", {24'b0, o_result}, 32'd0);
        chk("shrst flags", {27'b0, cur_flags()}, 32'd0);
        chk("shrst ready", {31'b0, o_ready}, 32'd1);
        begin
            int seen;
            seen = 0;
            repeat (12) begin
                @(negedge clk);
                if (o_valid) seen++;
            end
            chk("shrst no valid", seen, 0);
        end

        // Reset while holding a result in DONE.
        @(negedge clk);
        i_op = 6'b100000; i_a = 8'h10; i_b = 8'h20; i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        chk("done pre valid", {31'b0, o_valid}, 32'd1);
        chk("done pre result", {24'b0, o_result}, 32'h30);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        #1;
        chk("donerst valid", {31'b0, o_valid}, 32'd0);
        chk("donerst result", {24'b0, o_result}, 32'd0);
        chk("donerst ready", {31'b0, o_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter NB_DATA, default 8: operand/result width, SHALL be >= 2.
REQ-002 Parameter NB_OP, default 6: opcode width, SHALL be >= 6.
REQ-003 Parameter NB_SHAMT, default 3: shift-amount width, SHALL equal ceil(log2(NB_DATA)).
REQ-004 i_clk  in  1  single clock; all state updates on rising edge.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 i_valid  in  1  upstream operation request.
REQ-007 o_ready  out  1  block accepts a request this cycle.
REQ-008 i_a, i_b  in  NB_DATA each  operands; i_b[NB_SHAMT-1:0] is the shift amount for shifts.
REQ-009 i_op  in  NB_OP  opcode.
REQ-010 o_valid  out  1  result and flags valid.
REQ-011 i_ready  in  1  downstream consumes result.
REQ-012 o_result  out  NB_DATA  registered result.
REQ-013 o_zero, o_negative, o_carry, o_overflow, o_illegal  out  1 each  registered flags.

Function
REQ-014 Accept SHALL occur on a rising edge where i_valid && o_ready; i_a, i_b, i_op captured at that edge; inputs ignored otherwise.
REQ-015 FSM states IDLE, SHIFT, DONE; o_ready = 1 only in IDLE; o_valid = 1 only in DONE.
REQ-016 IDLE -> DONE on accept of a single-cycle op, or of a shift with shamt = 0; IDLE -> SHIFT on accept of a shift with shamt > 0.
REQ-017 SHIFT: one-bit shift per cycle, shamt decremented; last shift edge -> DONE; o_valid asserted exactly 1 + shamt cycles after the accept edge.
REQ-018 DONE -> IDLE on edge with i_ready = 1; while i_ready = 0, o_result and all flags SHALL hold stable.
REQ-019 Opcodes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010 (signed A<B), SLTU 101011 (unsigned A<B), SLL 000000, SRL 000010 (zero fill), SRA 000011 (MSB fill); upper opcode bits beyond 6 SHALL be zero for a legal op.
REQ-020 ADD/SUB: result modulo 2^NB_DATA; o_carry = carry-out (ADD) or borrow (SUB, set when unsigned A<B); o_overflow = two's-complement signed overflow.
REQ-021 SLT/SLTU: o_result = 1 if true, else 0 (zero-extended).
REQ-022 Shifts: o_carry = last bit shifted out (0 if shamt = 0); o_overflow = 0.
REQ-023 Logic ops, SLT, SLTU: o_carry = 0, o_overflow = 0.
REQ-024 o_zero = (o_result == 0); o_negative = o_result[NB_DATA-1]; for all ops, including illegal.
REQ-025 Illegal opcode: o_result = 0, o_illegal = 1, o_zero = 1, other flags 0, latency 1 (IDLE -> DONE); o_illegal = 0 for legal ops.

Reset
REQ-026 While i_reset = 1 at a rising edge: state -> IDLE; o_result, all flags, o_valid cleared to 0; o_ready = 0 while i_reset is high, 1 in first cycle after deassertion.
REQ-027 Reset SHALL take priority over accept, shift and handshake in any state; an operation in SHIFT or DONE is discarded with no o_valid pulse.

Verification (NB_DATA = 8)
REQ-028 ADD a=0x7F b=0x01 -> o_valid 1 cycle after accept, result 0x80, overflow=1, carry=0, negative=1, zero=0.
REQ-029 SUB a=0x05 b=0x05 -> 0x00, zero=1, carry=0; SUB a=0x03 b=0x05 -> 0xFE, carry=1, overflow=0, negative=1.
REQ-030 SRA a=0x90 b=0x03 -> 0xF2, carry=0, o_valid 4 cycles after accept; SRL same operands -> 0x12; SLL a=0x81 b=0x01 -> 0x02, carry=1.
REQ-031 Backpressure: ADD accepted, i_ready=0 for 3 cycles with i_valid=1 and new operands -> o_valid and result held, o_ready=0, no second accept until after i_ready=1 edge.
REQ-032 Illegal opcode 6'b111111 -> result 0x00, illegal=1, zero=1, o_valid 1 cycle after accept; following legal SLT a=0xFF b=0x01 -> 0x01, illegal=0.
REQ-033 i_reset=1 for one cycle during SHIFT (SRL b=0x07) -> next cycle IDLE, o_valid=0, outputs 0x00, no result ever presented for that op.
